// File: rtl/dll_lock_tracker.sv
// dll_lock_tracker: DLL code acquisition from a SAR, then bang-bang vote tracking
// with lock/unlock detection and rail protection.
module dll_lock_tracker #(
    parameter int SAR_CYCLES = 10,
    parameter int WIN        = 8,
    parameter int UP_TH      = 6,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic       clk4,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       comp,
    input  logic [9:0] sar_q,
    output logic       sar_restart_n,
    output logic [9:0] code,
    output logic       locked,
    output logic       range_err
);
    typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    localparam logic [15:0] SAR_N    = 16'(SAR_CYCLES);
    localparam logic [4:0]  WIN_LAST = 5'(WIN - 1);
    localparam logic [4:0]  UP_N     = 5'(UP_TH);
    localparam logic [4:0]  DN_N     = 5'(WIN - UP_TH);
    localparam logic [7:0]  LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0]  UNLOCK_N = 8'(UNLOCK_CNT);

    state_t      state_q, state_d;
    dir_t        prev_dir_q, prev_dir_d, step_dir;
    logic [9:0]  code_q, code_d;
    logic        locked_q, locked_d, range_err_q, range_err_d, restart_n_q, restart_n_d;
    logic [15:0] search_cnt_q, search_cnt_d;
    logic [4:0]  samp_cnt_q, samp_cnt_d, up_cnt_q, up_cnt_d, ups;
    logic [7:0]  lock_run_q, lock_run_d, same_run_q, same_run_d;
    logic        win_end, step_up, step_dn, same_dir, opp_dir, at_rail;

    // The sample arriving this edge is part of its own window's vote.
    assign ups      = up_cnt_q + 5'(comp);
    assign win_end  = samp_cnt_q == WIN_LAST;
    assign step_up  = ups >= UP_N;
    assign step_dn  = !step_up && ups <= DN_N;
    assign step_dir = step_up ? DIR_UP : step_dn ? DIR_DN : DIR_NONE;
    assign same_dir = step_dir != DIR_NONE && step_dir == prev_dir_q;
    assign opp_dir  = step_dir != DIR_NONE && prev_dir_q != DIR_NONE && step_dir != prev_dir_q;
    assign at_rail  = (step_up && &code_q) || (step_dn && ~|code_q);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        locked_d     = locked_q;
        range_err_d  = range_err_q;
        restart_n_d  = 1'b1;
        search_cnt_d = search_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        up_cnt_d     = up_cnt_q;
        lock_run_d   = lock_run_q;
        same_run_d   = same_run_q;
        prev_dir_d   = prev_dir_q;
        case (state_q)
            IDLE: if (enable) begin
                state_d      = SEARCH;
                restart_n_d  = 1'b0;
                search_cnt_d = '0;
                range_err_d  = 1'b0;
            end
            SEARCH: if (restart_n_q) begin
                search_cnt_d = search_cnt_q + 16'd1;
                code_d       = sar_q;
                if (search_cnt_d == SAR_N) begin
                    state_d    = TRACK;
                    samp_cnt_d = '0;
                    up_cnt_d   = '0;
                    lock_run_d = '0;
                    same_run_d = '0;
                    prev_dir_d = DIR_NONE;
                end
            end
            TRACK: begin
                samp_cnt_d = samp_cnt_q + 5'd1;
                up_cnt_d   = ups;
                if (win_end) begin
                    samp_cnt_d = '0;
                    up_cnt_d   = '0;
                    if (at_rail) begin
                        state_d      = SEARCH;
                        restart_n_d  = 1'b0;
                        search_cnt_d = '0;
                        range_err_d  = 1'b1;
                        locked_d     = 1'b0;
                        lock_run_d   = '0;
                        same_run_d   = '0;
                        prev_dir_d   = DIR_NONE;
                    end else begin
                        code_d     = step_up ? code_q + 10'd1 : step_dn ? code_q - 10'd1 : code_q;
                        prev_dir_d = step_dir == DIR_NONE ? prev_dir_q : step_dir;
                        same_run_d = step_dir == DIR_NONE ? 8'd0 : !same_dir ? 8'd1 :
                                     &same_run_q ? same_run_q : same_run_q + 8'd1;
                        lock_run_d = same_dir ? 8'd0 :
                                     (step_dir == DIR_NONE || opp_dir) && lock_run_q != LOCK_N ? lock_run_q + 8'd1 :
                                     lock_run_q;
                        if (lock_run_d == LOCK_N) locked_d = 1'b1;
                        if (locked_q && same_run_d >= UNLOCK_N) begin
                            locked_d   = 1'b0;
                            lock_run_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d      = IDLE;
            code_d       = code_q;
            locked_d     = 1'b0;
            range_err_d  = range_err_q;
            restart_n_d  = 1'b1;
            search_cnt_d = '0;
            samp_cnt_d   = '0;
            up_cnt_d     = '0;
            lock_run_d   = '0;
            same_run_d   = '0;
            prev_dir_d   = DIR_NONE;
        end
    end

    always_ff @(posedge clk4 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= 10'd512;
            locked_q     <= 1'b0;
            range_err_q  <= 1'b0;
            restart_n_q  <= 1'b1;
            search_cnt_q <= '0;
            samp_cnt_q   <= '0;
            up_cnt_q     <= '0;
            lock_run_q   <= '0;
            same_run_q   <= '0;
            prev_dir_q   <= DIR_NONE;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            locked_q     <= locked_d;
            range_err_q  <= range_err_d;
            restart_n_q  <= restart_n_d;
            search_cnt_q <= search_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            up_cnt_q     <= up_cnt_d;
            lock_run_q   <= lock_run_d;
            same_run_q   <= same_run_d;
            prev_dir_q   <= prev_dir_d;
        end
    end

    assign sar_restart_n = restart_n_q;
    assign code          = code_q;
    assign locked        = locked_q;
    assign range_err     = range_err_q;
endmodule
